// File: rtl/note_decoder_if.sv
// Key-number bus between the switch coder and the note decoder, plus the
// decoder's event/voice outputs toward the envelope and tone generators.
interface note_decoder_if;
  logic [2:0] num_i;
  logic       num_val_i;
  logic [2:0] note_o;
  logic [7:0] onehot_o;
  logic       gate_o;
  logic       active_o;
  logic       note_on_o;
  logic       note_off_o;

  modport master (
    output num_i, num_val_i,
    input  note_o, onehot_o, gate_o, active_o, note_on_o, note_off_o
  );

  modport slave (
    input  num_i, num_val_i,
    output note_o, onehot_o, gate_o, active_o, note_on_o, note_off_o
  );
endinterface

// File: rtl/note_decoder.sv
// Glitch-filters the switch coder's key number and tracks the voice through
// IDLE / ACTIVE / RELEASE, producing note events, gate and key LEDs.
module note_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned RELEASE_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  note_decoder_if.slave bus
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Input stage
  logic [3:0]    sample_d, sample_q;
  logic [SW-1:0] stb_cnt_d, stb_cnt_q;
  logic          acc_d, acc_q;
  logic          same;

  // Voice FSM and registered outputs
  state_e        state_d, state_q;
  logic [RW-1:0] rel_cnt_d, rel_cnt_q;
  logic [2:0]    note_d, note_q;
  logic [7:0]    onehot_d, onehot_q;
  logic          gate_d, gate_q;
  logic          active_d, active_q;
  logic          note_on_d, note_on_q;
  logic          note_off_d, note_off_q;

  logic          s_val;
  logic [2:0]    s_num;

  assign sample_d = {bus.num_val_i, bus.num_i};
  assign same     = (sample_d == sample_q);
  assign s_val    = sample_q[3];
  assign s_num    = sample_q[2:0];

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    stb_cnt_d = stb_cnt_q;
    if (!same) begin
      stb_cnt_d = '0;
    end else if (stb_cnt_q != SW'(STABLE_CYCLES)) begin
      stb_cnt_d = stb_cnt_q + SW'(1);
    end
  end

  // Only the transition into saturation is an event, so a held key fires once.
  assign acc_d = same && (stb_cnt_q == SW'(STABLE_CYCLES - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q  <= '0;
      stb_cnt_q <= '0;
      acc_q     <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      stb_cnt_q <= stb_cnt_d;
      acc_q     <= acc_d;
    end
  end

  // FSM state register, including the registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rel_cnt_q  <= '0;
      note_q     <= '0;
      onehot_q   <= '0;
      gate_q     <= 1'b0;
      active_q   <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rel_cnt_q  <= rel_cnt_d;
      note_q     <= note_d;
      onehot_q   <= onehot_d;
      gate_q     <= gate_d;
      active_q   <= active_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
    end
  end

  // FSM next state; a retrigger in RELEASE wins over release expiry
  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_q && s_val) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (acc_q && !s_val) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = '0;
        end
      end
      ST_RELEASE: begin
        if (acc_q && s_val) begin
          state_d   = ST_ACTIVE;
          rel_cnt_d = '0;
        end else if (rel_cnt_q == RW'(RELEASE_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rel_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs, computed from the transition and registered above
  always_comb begin
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    case (state_q)
      ST_IDLE:    note_on_d  = acc_q && s_val;
      ST_ACTIVE: begin
        note_on_d  = acc_q && s_val && (s_num != note_q);
        note_off_d = acc_q && !s_val;
      end
      ST_RELEASE: note_on_d  = acc_q && s_val;
      default:    note_on_d  = 1'b0;
    endcase
    note_d   = note_on_d ? s_num : note_q;
    gate_d   = (state_d == ST_ACTIVE);
    active_d = (state_d != ST_IDLE);
    onehot_d = active_d ? (8'd1 << note_d) : 8'h00;
  end

  assign bus.note_o     = note_q;
  assign bus.onehot_o   = onehot_q;
  assign bus.gate_o     = gate_q;
  assign bus.active_o   = active_q;
  assign bus.note_on_o  = note_on_q;
  assign bus.note_off_o = note_off_q;

endmodule

// File: tb/tb_note_decoder.sv
// Directed bench for note_decoder: vector table of held inputs with expected
// end state and pulse counts, plus hand sequences for reset behaviour.
module tb_note_decoder;

  localparam int STABLE  = 4;
  localparam int RELEASE = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  note_decoder_if bus ();

  note_decoder #(
    .STABLE_CYCLES (STABLE),
    .RELEASE_CYCLES(RELEASE)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       val;
    logic [2:0] num;
    int         cycles;
    logic [2:0] note;
    logic [7:0] onehot;
    logic       gate;
    logic       active;
    int         ons;
    int         offs;
  } vec_t;

  vec_t vecs[13];
  int   errors = 0;
  int   checks = 0;
  int   on_cnt, off_cnt, both_cnt;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance one edge and sample away from it, tallying pulses.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (bus.note_on_o === 1'b1) on_cnt++;
    if (bus.note_off_o === 1'b1) off_cnt++;
    if (bus.note_on_o === 1'b1 && bus.note_off_o === 1'b1) both_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_note"},   32'(bus.note_o),     32'd0);
    check({tag, "_onehot"}, 32'(bus.onehot_o),   32'd0);
    check({tag, "_gate"},   32'(bus.gate_o),     32'd0);
    check({tag, "_active"}, 32'(bus.active_o),   32'd0);
    check({tag, "_on"},     32'(bus.note_on_o),  32'd0);
    check({tag, "_off"},    32'(bus.note_off_o), 32'd0);
  endtask

  initial begin
    int edges;
    bit seen;

    // A key counts as stable once the sample has stayed unchanged for STABLE
    // edges after the edge that loaded it; the event lands one edge later.
    vecs[0]  = '{1'b1, 3'd5, 10, 3'd5, 8'h20, 1'b1, 1'b1, 1, 0}; // press 5
    vecs[1]  = '{1'b1, 3'd2, 10, 3'd2, 8'h04, 1'b1, 1'b1, 1, 0}; // legato to 2
    vecs[2]  = '{1'b1, 3'd2, 10, 3'd2, 8'h04, 1'b1, 1'b1, 0, 0}; // held: quiet
    vecs[3]  = '{1'b0, 3'd0,  6, 3'd2, 8'h04, 1'b0, 1'b1, 0, 1}; // key-up
    vecs[4]  = '{1'b0, 3'd0,  7, 3'd2, 8'h04, 1'b0, 1'b1, 0, 0}; // last release cycle
    vecs[5]  = '{1'b0, 3'd0,  1, 3'd2, 8'h00, 1'b0, 1'b0, 0, 0}; // expiry edge
    vecs[6]  = '{1'b1, 3'd3,  4, 3'd2, 8'h00, 1'b0, 1'b0, 0, 0}; // short glitch
    vecs[7]  = '{1'b0, 3'd0, 10, 3'd2, 8'h00, 1'b0, 1'b0, 0, 0}; // glitch ignored
    vecs[8]  = '{1'b1, 3'd3,  5, 3'd2, 8'h00, 1'b0, 1'b0, 0, 0}; // just long enough
    vecs[9]  = '{1'b0, 3'd0,  1, 3'd3, 8'h08, 1'b1, 1'b1, 1, 0}; // ...fires here
    vecs[10] = '{1'b0, 3'd0,  7, 3'd3, 8'h08, 1'b0, 1'b1, 0, 1}; // into release
    vecs[11] = '{1'b1, 3'd7,  6, 3'd7, 8'h80, 1'b1, 1'b1, 1, 0}; // retrigger on expiry edge
    vecs[12] = '{1'b1, 3'd7, 20, 3'd7, 8'h80, 1'b1, 1'b1, 0, 0}; // no late expiry

    bus.num_i     = 3'd0;
    bus.num_val_i = 1'b0;

    // Reset with no clock edge yet
    #1 rst_i = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    on_cnt = 0; off_cnt = 0; both_cnt = 0;
    repeat (20) step();
    check("idle_on_pulses",  32'(on_cnt),  32'd0);
    check("idle_off_pulses", 32'(off_cnt), 32'd0);
    check("idle_active",     32'(bus.active_o), 32'd0);
    check("idle_onehot",     32'(bus.onehot_o), 32'd0);

    foreach (vecs[i]) begin
      bus.num_val_i = vecs[i].val;
      bus.num_i     = vecs[i].num;
      on_cnt = 0; off_cnt = 0; both_cnt = 0;
      repeat (vecs[i].cycles) step();
      check($sformatf("row%0d_note", i),   32'(bus.note_o),   32'(vecs[i].note));
      check($sformatf("row%0d_onehot", i), 32'(bus.onehot_o), 32'(vecs[i].onehot));
      check($sformatf("row%0d_gate", i),   32'(bus.gate_o),   32'(vecs[i].gate));
      check($sformatf("row%0d_active", i), 32'(bus.active_o), 32'(vecs[i].active));
      check($sformatf("row%0d_ons", i),    32'(on_cnt),       32'(vecs[i].ons));
      check($sformatf("row%0d_offs", i),   32'(off_cnt),      32'(vecs[i].offs));
      check($sformatf("row%0d_overlap", i), 32'(both_cnt),    32'd0);
    end

    // Reset while ACTIVE on 7, between edges
    #3 rst_i = 1'b1;
    #1;
    check_all_zero("midreset");
    #2 rst_i = 1'b0;

    // Key 7 still held: fresh acceptance after the full filter latency
    edges = 0; seen = 1'b0; on_cnt = 0; off_cnt = 0; both_cnt = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (on_cnt != 0) begin
        seen  = 1'b1;
        edges = i;
      end
    end
    check("rearm_seen",    32'(seen),         32'd1);
    check("rearm_latency", 32'(edges),        32'(STABLE + 2));
    check("rearm_offs",    32'(off_cnt),      32'd0);
    check("rearm_note",    32'(bus.note_o),   32'd7);
    check("rearm_onehot",  32'(bus.onehot_o), 32'h80);
    check("rearm_gate",    32'(bus.gate_o),   32'd1);

    step();
    check("rearm_on_width", 32'(bus.note_on_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
